regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised successor register file for the multi-cycle CPU. It has NUM_RD
//  read ports and one write port, with register 0 hardwired to zero.
//  A per-register busy scoreboard lets control stall reads of registers whose
//  producer has not written back.
//  Reset starts a sweep FSM that clears one entry per cycle (no reset fan-out).
// PARAMETERS
//  DATA_WIDTH  32  width of each register
//  ADDR_WIDTH  5   address width; DEPTH = 2**ADDR_WIDTH entries
//  NUM_RD      2   number of read ports (flattened buses, port p at slice p)
// PORTS
//  clk       in   1                    clock, all state on rising edge
//  reset     in   1                    synchronous, active-high
//  ready     out  1                    1 = clear sweep done, ports live
//  rd_addr   in   NUM_RD*ADDR_WIDTH    read addresses
//  rd_data   out  NUM_RD*DATA_WIDTH    read data (combinational)
//  rd_busy   out  NUM_RD               busy bit of addressed register (combinational)
//  wr_en     in   1                    write strobe
//  wr_addr   in   ADDR_WIDTH           write address
//  wr_data   in   DATA_WIDTH           write data
//  iss_en    in   1                    issue: mark iss_addr busy (new producer)
//  iss_addr  in   ADDR_WIDTH           destination being issued
// BEHAVIOUR
//  - Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
//  - FSM states: CLEAR and READY.
//  - Reset sampled high: state<=CLEAR, clr_idx<=1, busy<=0, ready<=0.
//    Reset during an in-progress sweep restarts at clr_idx=1.
//  - CLEAR: each edge writes RF[clr_idx]<=0 and increments clr_idx.
//    The edge that clears DEPTH-1 moves to READY and sets ready<=1.
//    So ready rises DEPTH-1 edges after the first edge with reset low.
//  - In CLEAR, wr_en and iss_en are ignored, rd_data=0 and rd_busy=0.
//  - Read (READY): rd_data[p] = (rd_addr[p]==0) ? 0 : RF[rd_addr[p]].
//    rd_busy[p] = busy[rd_addr[p]]. busy[0] is constant 0.
//  - Write (READY, wr_en, wr_addr!=0): RF[wr_addr]<=wr_data and busy[wr_addr]<=0.
//    Writes to address 0 are dropped.
//  - Issue (READY, iss_en, iss_addr!=0): busy[iss_addr]<=1.
//  - Write and issue to the same address in one cycle: data is written, busy ends 1
//    (issue wins, a younger producer exists).
//  - Write and issue to different addresses: both take effect.
//  - Issuing an already-busy register: it stays busy (no counting).
//  - Output reset values: ready=0, rd_data=0, rd_busy=0 from the reset edge until ready.
// CONFIGURATION
//  Macro RF_WRITE_BYPASS_EN controls same-cycle write forwarding.
//  - Defined: in READY, if wr_en && wr_addr!=0 && wr_addr==rd_addr[p], then
//    rd_data[p]=wr_data and rd_busy[p]=0 in the same cycle (write-before-read).
//  - Undefined: reads return the stored value and busy bit until the write edge
//    (read-before-write), one extra cycle to see new data.
// TESTING
//  1. Reset 1 cycle, then low -> ready=0 for 31 edges, 1 on the 31st.
//     Every rd_data then reads 0 (DEPTH=32).
//  2. Write r5=0xDEADBEEF, read r5 on port 1 next cycle -> 0xDEADBEEF.
//     Write r0=0x1234 -> r0 still reads 0.
//  3. Issue r7 -> rd_busy=1 for r7 next cycle. Write r7=0x55 -> busy=0 and data=0x55
//     after the edge.
//  4. Same cycle: wr_en r9=0xA and iss_en r9 -> after edge r9 reads 0xA, rd_busy=1.
//  5. Read r3 while writing r3=0x77:
//     - with RF_WRITE_BYPASS_EN: rd_data=0x77 and rd_busy=0 in the same cycle;
//     - without the macro: old value until the edge.
//  6. Assert reset at mid-sweep (clr_idx=12), after r12 was written -> sweep restarts.
//     ready rises 31 edges after reset falls, and r12 reads 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with NUM_RD read ports, one write port, r0 hardwired to zero, and a per-register busy scoreboard.
// After reset, a sweep clears one entry per cycle. Define RF_WRITE_BYPASS_EN to forward a same-cycle write to the reads.
module regfile_scoreboard #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_RD     = 2
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   output logic                         o_ready,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0] o_rd_data,
   output logic [NUM_RD-1:0]            o_rd_busy,
   input  logic                         i_wr_en,
   input  logic [ADDR_WIDTH-1:0]        i_wr_addr,
   input  logic [DATA_WIDTH-1:0]        i_wr_data,
   input  logic                         i_iss_en,
   input  logic [ADDR_WIDTH-1:0]        i_iss_addr
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

   typedef enum logic {S_CLEAR, S_READY} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_clr_idx;
   logic [DATA_WIDTH-1:0]   r_rf [DEPTH];
   logic [DEPTH-1:0]        r_busy;
   logic                    w_wr_ok;
   logic                    w_iss_ok;

   assign w_wr_ok  = (r_state == S_READY) && i_wr_en  && (i_wr_addr  != '0);
   assign w_iss_ok = (r_state == S_READY) && i_iss_en && (i_iss_addr != '0);
   assign o_ready  = (r_state == S_READY);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= S_CLEAR;
         r_clr_idx <= ADDR_WIDTH'(1);
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_CLEAR)
            r_clr_idx <= r_clr_idx + ADDR_WIDTH'(1);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_CLEAR: if (r_clr_idx == LAST_IDX) w_state_nxt = S_READY;
         S_READY: w_state_nxt = S_READY;
         default: w_state_nxt = S_CLEAR;
      endcase
   end

   // Storage has no reset; the sweep zeroes it one entry per cycle instead.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         if (r_state == S_CLEAR)
            r_rf[r_clr_idx] <= '0;
         else if (w_wr_ok)
            r_rf[i_wr_addr] <= i_wr_data;
      end
   end

   // The issue is applied last, so it wins over a same-address write-back.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_busy <= '0;
      end else begin
         if (w_wr_ok)
            r_busy[i_wr_addr] <= 1'b0;
         if (w_iss_ok)
            r_busy[i_iss_addr] <= 1'b1;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_addr;
      logic                  w_live;
      logic                  w_hit;

      assign w_addr = i_rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_live = (r_state == S_READY) && (w_addr != '0);
`ifdef RF_WRITE_BYPASS_EN
      assign w_hit  = w_wr_ok && (i_wr_addr == w_addr);
`else
      assign w_hit  = 1'b0;
`endif
      assign o_rd_data[p*DATA_WIDTH +: DATA_WIDTH] = !w_live ? '0 :
                                                     w_hit   ? i_wr_data : r_rf[w_addr];
      assign o_rd_busy[p] = w_live && !w_hit && r_busy[w_addr];
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset sweep timing, a table of write/issue/read vectors, bypass behaviour and mid-sweep reset.
module tb_regfile_scoreboard;

   logic        clk;
   logic        reset;
   logic        ready;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        iss_en;
   logic [4:0]  iss_addr;

   int n_checks = 0;
   int n_errors = 0;

   regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2)) dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .o_ready    (ready),
      .i_rd_addr  (rd_addr),
      .o_rd_data  (rd_data),
      .o_rd_busy  (rd_busy),
      .i_wr_en    (wr_en),
      .i_wr_addr  (wr_addr),
      .i_wr_data  (wr_data),
      .i_iss_en   (iss_en),
      .i_iss_addr (iss_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, time %0t required end before 500000", $time);
      $fatal(1);
   end

   typedef struct {
      logic        wr_en;
      logic [4:0]  wr_addr;
      logic [31:0] wr_data;
      logic        iss_en;
      logic [4:0]  iss_addr;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] ed0;
      logic [31:0] ed1;
      logic        eb0;
      logic        eb1;
   } vec_t;

   vec_t vecs [12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!ready && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic idle_ports();
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      iss_en = 1'b0; iss_addr = '0;
   endtask

   initial begin
      int n;

      vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  5'd5,  32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 5'd7,  32'h00000055, 1'b0, 5'd0,  5'd7,  5'd0,  32'h55,       32'h0,        1'b0, 1'b0};
      vecs[4]  = '{1'b1, 5'd9,  32'h0000000A, 1'b1, 5'd9,  5'd9,  5'd7,  32'hA,        32'h55,       1'b1, 1'b0};
      vecs[5]  = '{1'b1, 5'd10, 32'h00001111, 1'b1, 5'd11, 5'd10, 5'd11, 32'h1111,     32'h0,        1'b0, 1'b1};
      vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 5'd11, 5'd9,  32'h0,        32'hA,        1'b1, 1'b1};
      vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
      vecs[8]  = '{1'b1, 5'd11, 32'h00002222, 1'b0, 5'd0,  5'd11, 5'd10, 32'h2222,     32'h1111,     1'b0, 1'b0};
      vecs[9]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd1,  5'd31, 5'd1,  32'hFFFFFFFF, 32'h0,        1'b0, 1'b1};
      vecs[10] = '{1'b1, 5'd1,  32'h0000000C, 1'b0, 5'd0,  5'd1,  5'd31, 32'hC,        32'hFFFFFFFF, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  32'hA,        32'hA,        1'b1, 1'b1};

      // Reset and first sweep; writes and issues held active must be ignored
      reset = 1'b1;
      idle_ports();
      rd_addr = {5'd3, 5'd2};
      tick();
      chk("reset_ready", {31'd0, ready}, 32'd0);
      chk("reset_rd_data0", rd_data[31:0], 32'd0);
      chk("reset_rd_data1", rd_data[63:32], 32'd0);
      chk("reset_rd_busy", {30'd0, rd_busy}, 32'd0);

      reset = 1'b0;
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000FFFF;
      iss_en = 1'b1; iss_addr = 5'd6;
      rd_addr = {5'd6, 5'd5};
      wait_ready(n);
      idle_ports();
      #1;
      chk("sweep_edges", n, 31);
      chk("sweep_ignored_write", rd_data[31:0], 32'd0);
      chk("sweep_ignored_issue", {30'd0, rd_busy}, 32'd0);
      for (int a = 0; a < 32; a += 2) begin
         rd_addr = {5'(a + 1), 5'(a)};
         #1;
         chk($sformatf("sweep_zero_r%0d", a), rd_data[31:0], 32'd0);
         chk($sformatf("sweep_zero_r%0d", a + 1), rd_data[63:32], 32'd0);
      end

      // Table of write/issue vectors, outputs checked after the edge
      for (int i = 0; i < 12; i++) begin
         wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
         iss_en = vecs[i].iss_en; iss_addr = vecs[i].iss_addr;
         rd_addr = {vecs[i].ra1, vecs[i].ra0};
         tick();
         idle_ports();
         #1;
         chk($sformatf("vec%0d_data0", i), rd_data[31:0], vecs[i].ed0);
         chk($sformatf("vec%0d_data1", i), rd_data[63:32], vecs[i].ed1);
         chk($sformatf("vec%0d_busy0", i), {31'd0, rd_busy[0]}, {31'd0, vecs[i].eb0});
         chk($sformatf("vec%0d_busy1", i), {31'd0, rd_busy[1]}, {31'd0, vecs[i].eb1});
      end

      // Same-cycle read of a register being written
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
      iss_en = 1'b1; iss_addr = 5'd3;
      rd_addr = {5'd0, 5'd3};
      tick();
      idle_ports();
      #1;
      chk("byp_pre_data", rd_data[31:0], 32'h33);
      chk("byp_pre_busy", {31'd0, rd_busy[0]}, 32'd1);
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
      #1;
`ifdef RF_WRITE_BYPASS_EN
      chk("byp_same_data", rd_data[31:0], 32'h77);
      chk("byp_same_busy", {31'd0, rd_busy[0]}, 32'd0);
`else
      chk("byp_same_data", rd_data[31:0], 32'h33);
      chk("byp_same_busy", {31'd0, rd_busy[0]}, 32'd1);
`endif
      tick();
      idle_ports();
      #1;
      chk("byp_post_data", rd_data[31:0], 32'h77);
      chk("byp_post_busy", {31'd0, rd_busy[0]}, 32'd0);

      // Reset in the middle of a sweep restarts it
      wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h12;
      tick();
      idle_ports();
      rd_addr = {5'd9, 5'd12};
      #1;
      chk("mid_pre_r12", rd_data[31:0], 32'h12);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 11; k++) begin
         tick();
         if (k == 4) begin
            chk("mid_clear_rd_data", rd_data[31:0], 32'd0);
            chk("mid_clear_rd_busy", {30'd0, rd_busy}, 32'd0);
         end
      end
      chk("mid_ready_low", {31'd0, ready}, 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      wait_ready(n);
      chk("mid_restart_edges", n, 31);
      chk("mid_r12_zero", rd_data[31:0], 32'd0);
      chk("mid_r9_zero", rd_data[63:32], 32'd0);
      chk("mid_busy_clear", {30'd0, rd_busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
